// File: rtl/cycle_controller.sv
// cycle_controller: multi-cycle FETCH/EXEC1/EXEC2 sequencer with halt and instruction/load latches
module cycle_controller #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_halt,
  input  logic [31:0] readdata,
  input  logic        alu_busy,
  input  logic [31:0] pc_next,
  output logic        fetch,
  output logic        exec1,
  output logic        exec2,
  output logic [31:0] instr_word,
  output logic [31:0] load_word,
  output logic        pc_en,
  output logic        reg_write_en,
  output logic        pc_load_reset,
  output logic [31:0] pc_reset_val,
  output logic        active
);
  typedef enum logic [1:0] {FETCH, EXEC1, EXEC2, HALTED} state_t;
  state_t state, state_nx;
  logic retire;
  // state register plus the one-cycle-valid readdata latches and the run flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      instr_word <= '0;
      load_word <= '0;
      active <= 1'b1;
    end else begin
      state <= state_nx;
      if (state == FETCH && !mem_halt) instr_word <= readdata;
      if (state == EXEC1 && !mem_halt) load_word <= readdata;
      if (retire && pc_next == HALT_ADDR) active <= 1'b0;
    end
  end
  // phase decode, retire pulse and next-state selection
  always_comb begin
    fetch = state == FETCH;
    exec1 = state == EXEC1;
    exec2 = state == EXEC2;
    retire = exec2 && !alu_busy && !reset;
    pc_en = retire;
    reg_write_en = retire;
    pc_load_reset = reset;
    pc_reset_val = RESET_VECTOR;
    state_nx = state;
    case (state)
      FETCH:   state_nx = mem_halt ? FETCH : EXEC1;
      EXEC1:   state_nx = mem_halt ? EXEC1 : EXEC2;
      EXEC2:   state_nx = alu_busy ? EXEC2 : (pc_next == HALT_ADDR ? HALTED : FETCH);
      default: state_nx = HALTED;
    endcase
  end
endmodule

// File: tb/tb_cycle_controller.sv
// tb_cycle_controller: directed plus randomized checks of cycle_controller against a behavioural model
module tb_cycle_controller;
  logic clk = 1'b0;
  logic reset, mem_halt, alu_busy;
  logic [31:0] readdata, pc_next;
  logic fetch, exec1, exec2, pc_en, reg_write_en, pc_load_reset, active;
  logic [31:0] instr_word, load_word, pc_reset_val;
  int vectors = 0;
  int miscompares = 0;
  int pulses = 0;
  int m_phase;
  logic [31:0] m_instr, m_load;
  logic m_active;

  cycle_controller dut (
    .clk(clk), .reset(reset), .mem_halt(mem_halt), .readdata(readdata),
    .alu_busy(alu_busy), .pc_next(pc_next), .fetch(fetch), .exec1(exec1),
    .exec2(exec2), .instr_word(instr_word), .load_word(load_word), .pc_en(pc_en),
    .reg_write_en(reg_write_en), .pc_load_reset(pc_load_reset),
    .pc_reset_val(pc_reset_val), .active(active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic mh, input logic [31:0] rd, input logic ab, input logic [31:0] pn);
    logic retire;
    reset = r;
    mem_halt = mh;
    readdata = rd;
    alu_busy = ab;
    pc_next = pn;
    #1;
    retire = m_phase == 2 && !ab && !r;
    chk("fetch", 32'(fetch), 32'(m_phase == 0));
    chk("exec1", 32'(exec1), 32'(m_phase == 1));
    chk("exec2", 32'(exec2), 32'(m_phase == 2));
    chk("pc_en", 32'(pc_en), 32'(retire));
    chk("reg_write_en", 32'(reg_write_en), 32'(retire));
    chk("pc_load_reset", 32'(pc_load_reset), 32'(r));
    chk("pc_reset_val", pc_reset_val, 32'hBFC00000);
    chk("active", 32'(active), 32'(m_active));
    chk("instr_word", instr_word, m_instr);
    chk("load_word", load_word, m_load);
    if (pc_en) pulses++;
    @(posedge clk);
    if (r) begin
      m_phase = 0;
      m_instr = 0;
      m_load = 0;
      m_active = 1;
    end else if (m_phase == 0 && !mh) begin
      m_instr = rd;
      m_phase = 1;
    end else if (m_phase == 1 && !mh) begin
      m_load = rd;
      m_phase = 2;
    end else if (retire) begin
      m_phase = pn == 0 ? 3 : 0;
      if (pn == 0) m_active = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1; mem_halt = 0; alu_busy = 0; readdata = 0; pc_next = 32'h4;
    @(posedge clk);
    @(negedge clk);
    m_phase = 0; m_instr = 0; m_load = 0; m_active = 1;
    cyc(1, 0, 0, 0, 4);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 32'h24020005, 0, 32'hBFC00004);
      if (i == 0) chk("t1_instr", instr_word, 32'h24020005);
    end
    pulses = 0;
    for (int i = 0; i < 3; i++) cyc(0, 1, $urandom, 0, 4);
    cyc(0, 0, 32'hDEADBEEF, 0, 4);
    chk("t2_instr", instr_word, 32'hDEADBEEF);
    chk("t2_no_pulse", 32'(pulses), 0);
    for (int i = 0; i < 2; i++) cyc(0, 1, $urandom, 0, 4);
    cyc(0, 0, 32'h80FF0012, 0, 4);
    chk("t3_load", load_word, 32'h80FF0012);
    chk("t3_exec2", 32'(exec2), 1);
    pulses = 0;
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 4);
    cyc(0, 0, 0, 0, 4);
    chk("t4_one_pulse", 32'(pulses), 1);
    cyc(0, 0, 32'h11112222, 0, 4);
    cyc(0, 0, 32'h33334444, 0, 4);
    cyc(0, 0, 0, 0, 0);
    chk("t5_active", 32'(active), 0);
    pulses = 0;
    for (int i = 0; i < 20; i++) cyc(0, 1'($urandom), $urandom, 1'($urandom), 0);
    chk("t5_no_pulse", 32'(pulses), 0);
    chk("t5_instr_hold", instr_word, 32'h11112222);
    cyc(1, 1, 0, 1, 0);
    chk("t6_fetch", 32'(fetch), 1);
    chk("t6_active", 32'(active), 1);
    chk("t6_instr", instr_word, 0);
    cyc(0, 0, 32'h55556666, 0, 4);
    cyc(0, 1, 0, 0, 4);
    cyc(1, 1, 0, 0, 4);
    chk("t6b_fetch", 32'(fetch), 1);
    chk("t6b_instr", instr_word, 0);
    chk("t6b_load", load_word, 0);
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 39) == 0, $urandom_range(0, 2) == 0, $urandom,
          $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0 ? 32'h0 : $urandom | 32'h4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cycle_controller.md
Name: cycle_controller

Overview:
- Multi-cycle sequencer for the MIPS CPU.
- Generates the one-hot fetch/exec1/exec2 phase strobes that drive the memory access unit. The MXU consumes these strobes and returns mem_halt.
- Latches the instruction word at the end of FETCH and the raw load word at the end of EXEC1, because the Avalon readdata is valid for only one cycle.
- Owns PC-update timing, multi-cycle ALU stalls, and the halted/active state.

Parameters:
RESET_VECTOR, 32'hBFC00000, PC value reported on pc_reset_val and loaded by the PC unit when pc_load_reset is high
HALT_ADDR, 32'h00000000, next-PC value that terminates execution

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  synchronous, active-high reset
mem_halt  input  1  MXU stall: read or write is in progress with waitrequest high
readdata  input  32  Avalon readdata from memory
alu_busy  input  1  multi-cycle MULT/DIV unit still computing
pc_next  input  32  next-PC value computed by the PC/branch unit
fetch  output  1  FETCH phase strobe
exec1  output  1  EXEC1 phase strobe (memory data phase)
exec2  output  1  EXEC2 phase strobe (writeback / PC update)
instr_word  output  32  latched instruction register
load_word  output  32  latched raw memory word for load decode
pc_en  output  1  single-cycle PC update enable
reg_write_en  output  1  register-file write permission (the decoder ANDs it with its own write flag)
pc_load_reset  output  1  PC unit loads RESET_VECTOR
pc_reset_val  output  32  constant RESET_VECTOR
active  output  1  CPU running; low once halted

Behaviour:
- States: FETCH, EXEC1, EXEC2, HALTED, encoded in 2 bits.
- Phase strobes are decoded combinationally from the state and are exactly one-hot. In HALTED all three strobes are 0.
- Reset (synchronous, takes priority over every other condition, including mid-stall and HALTED):
  - state=FETCH, instr_word=0, load_word=0, active=1, pc_load_reset=1 for the reset cycle only.
  - pc_en=0 and reg_write_en=0 during reset.
- FETCH:
  - mem_halt=1: remain in FETCH, instr_word unchanged.
  - mem_halt=0: instr_word<=readdata, then go to EXEC1.
- EXEC1:
  - mem_halt=1: remain in EXEC1.
  - mem_halt=0: load_word<=readdata, then go to EXEC2.
  - load_word is captured whether or not the instruction is a load; the MXU decides whether to use it.
  - When the MXU raises no access in EXEC1, mem_halt=0 and the block advances after 1 cycle.
- EXEC2:
  - alu_busy=1: remain in EXEC2 with pc_en=0 and reg_write_en=0.
  - alu_busy=0: pc_en=1 and reg_write_en=1 for exactly this cycle.
  - Next state is HALTED if pc_next==HALT_ADDR, otherwise FETCH.
- HALTED: absorbing state. active=0; pc_en, reg_write_en and all strobes are 0; instr_word and load_word hold their values. Only reset leaves this state.
- active is registered and falls on the same edge that enters HALTED.
- Latency:
  - Un-stalled instruction: 3 cycles.
  - Each waitrequest cycle adds 1 cycle in the phase where it occurs.
  - Each alu_busy cycle adds 1 cycle in EXEC2.
- Simultaneous events:
  - mem_halt is ignored in EXEC2 and HALTED.
  - alu_busy is ignored outside EXEC2.
  - mem_halt and alu_busy never both stall the same cycle.
- pc_en and reg_write_en are never high outside EXEC2. They are high exactly once per executed instruction.
- Reset released mid-stall: the block restarts at FETCH. No partial latch from the interrupted instruction survives reset.

Test Plan:
- Reset, then mem_halt=0 and readdata=32'h24020005 throughout → fetch high on cycle 1, instr_word=32'h24020005 after cycle 1, exec1 on cycle 2, exec2 with pc_en=1 on cycle 3, fetch again on cycle 4.
- mem_halt held high for 3 cycles in FETCH, readdata=32'hDEADBEEF on the release cycle → fetch high for 4 cycles, instr_word=32'hDEADBEEF, no pc_en pulse during the stall.
- Load: mem_halt high for 2 cycles in EXEC1, readdata=32'h80FF0012 on release → load_word=32'h80FF0012, EXEC2 reached on the 3rd EXEC1 cycle.
- alu_busy high for 5 cycles in EXEC2 → exec2 high for 6 cycles, a single pc_en pulse in the last cycle only.
- pc_next=0 in EXEC2 → active falls on the next edge, state HALTED, strobes stay 0 for 20 cycles despite mem_halt/alu_busy toggling.
- Reset asserted during an EXEC1 stall and during HALTED → next cycle fetch=1, active=1, instr_word=0, load_word=0, pc_load_reset pulsed once.
